// File: rtl/riscv_div_unit_pkg.sv
// Shared divider definitions: FSM encodings, iteration count, func3 divide codes
// and the conditional two's-complement helper used for sign handling.
package riscv_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

    localparam int DIV_ITERATIONS = 32;
    localparam int DIV_COUNT_W    = $clog2(DIV_ITERATIONS);

    // Full func3 values of the M-extension divide group.
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    function automatic logic [31:0] negate_if(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/riscv_div_unit.sv
// Iterative 32-step restoring divider for RV32M DIV/DIVU/REM/REMU; stalls the
// front of the pipeline while busy and pulses done for one cycle with the result.
module riscv_div_unit
    import riscv_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [DIV_COUNT_W-1:0] LAST_COUNT = DIV_COUNT_W'(DIV_ITERATIONS - 1);

    div_state_t             state_reg, state_next;
    logic [DIV_COUNT_W-1:0] count_reg, count_next;
    logic                   is_rem_reg, is_rem_next;
    logic                   neg_q_reg, neg_q_next;
    logic                   neg_r_reg, neg_r_next;
    logic [31:0]            dividend_reg, dividend_next;
    logic [31:0]            divisor_reg, divisor_next;
    logic [31:0]            rem_reg, rem_next;
    logic                   done_reg, done_next;
    logic [31:0]            result_reg, result_next;

    logic [2:0]  f3;
    logic        acc_signed, acc_rem, op1_neg, op2_neg;
    logic        div_by_zero, signed_ovf;
    logic [32:0] partial, diff;
    logic        q_bit;

    assign f3          = {1'b1, div_op};
    assign acc_signed  = (f3 == F3_DIV) || (f3 == F3_REM);
    assign acc_rem     = (f3 == F3_REM) || (f3 == F3_REMU);
    assign op1_neg     = acc_signed & op1[31];
    assign op2_neg     = acc_signed & op2[31];
    assign div_by_zero = (op2 == 32'd0);
    assign signed_ovf  = acc_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

    // Partial remainder stays below the divisor, so the 33-bit difference is
    // negative exactly when bit 32 is set.
    assign partial = {rem_reg, dividend_reg[31]};
    assign diff    = partial - {1'b0, divisor_reg};
    assign q_bit   = ~diff[32];

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        is_rem_next   = is_rem_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        rem_next      = rem_reg;
        done_next     = 1'b0;
        result_next   = result_reg;

        if (flush) begin
            state_next = DIV_IDLE;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    // done=1 means the finished instruction is still in EX.
                    if (div_start && !done_reg) begin
                        if (div_by_zero) begin
                            result_next = acc_rem ? op1 : 32'hFFFF_FFFF;
                            done_next   = 1'b1;
                        end else if (signed_ovf) begin
                            result_next = acc_rem ? 32'd0 : 32'h8000_0000;
                            done_next   = 1'b1;
                        end else begin
                            is_rem_next   = acc_rem;
                            neg_q_next    = op1_neg ^ op2_neg;
                            neg_r_next    = op1_neg;
                            dividend_next = negate_if(op1, op1_neg);
                            divisor_next  = negate_if(op2, op2_neg);
                            rem_next      = 32'd0;
                            count_next    = '0;
                            state_next    = DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    // Quotient bits shift into the dividend register as it empties.
                    rem_next      = q_bit ? diff[31:0] : partial[31:0];
                    dividend_next = {dividend_reg[30:0], q_bit};
                    count_next    = count_reg + 1'b1;
                    if (count_reg == LAST_COUNT) begin
                        state_next = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    result_next = is_rem_reg ? negate_if(rem_reg, neg_r_reg)
                                             : negate_if(dividend_reg, neg_q_reg);
                    done_next   = 1'b1;
                    state_next  = DIV_IDLE;
                end
                default: state_next = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= DIV_IDLE;
            count_reg    <= '0;
            is_rem_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            dividend_reg <= 32'd0;
            divisor_reg  <= 32'd0;
            rem_reg      <= 32'd0;
            done_reg     <= 1'b0;
            result_reg   <= 32'd0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            is_rem_reg   <= is_rem_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            rem_reg      <= rem_next;
            done_reg     <= done_next;
            result_reg   <= result_next;
        end
    end

    assign stall  = (state_reg != DIV_IDLE) || (div_start && !done_reg);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed bench for riscv_div_unit: expected results and latencies are queued at
// issue and compared when done pulses; also covers flush, reset and back-to-back.
module tb_riscv_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        stall;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_result;

    riscv_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .div_start (div_start),
        .div_op    (div_op),
        .op1       (op1),
        .op2       (op2),
        .stall     (stall),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference built on the simulator's own division operators.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return sa / sbv;
            2'b01:   return a / b;
            2'b10:   return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    // Issues one divide and holds div_start through the done cycle; returns at the
    // done-cycle falling edge so the caller can issue back-to-back or go idle.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res);
        exp_t e;
        int   n;
        int   stall_cnt;
        bit   seen;
        e.res = exp_res;
        e.lat = is_special(op, a, b) ? 1 : 34;
        sb.push_back(e);
        @(negedge clk);
        div_start = 1'b1;
        div_op    = op;
        op1       = a;
        op2       = b;
        #1;
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
            else if (stall === 1'b1) stall_cnt++;
        end
        e = sb.pop_front();
        if (!seen) begin
            check({tag, " timeout"}, {31'd0, done}, 32'd1);
        end else begin
            check({tag, " result"}, result, e.res);
            check({tag, " latency"}, n, e.lat);
            check({tag, " stall_cycles"}, stall_cnt, e.lat);
            check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
            last_result = e.res;
        end
        $display("txn %s op=%0d a=%h b=%h result=%h cycles=%0d", tag, op, a, b, result, n);
    endtask

    task automatic idle_check(input string tag);
        div_start = 1'b0;
        @(negedge clk);
        check({tag, " single_done"}, {31'd0, done}, 32'd0);
        check({tag, " idle_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int spurious;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;

        rst       = 1'b1;
        flush     = 1'b0;
        div_start = 1'b0;
        div_op    = 2'b00;
        op1       = 32'd0;
        op2       = 32'd0;
        #1;
        check("reset result", result, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_div("div_20_m3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_div("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_div("remu_max_10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5);
        run_div("divu_max_10", 2'b01, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999);
        idle_check("b2b");

        run_div("divu_7_0", 2'b01, 32'd7, 32'd0, 32'hFFFF_FFFF);
        idle_check("divu_7_0");
        run_div("rem_7_0", 2'b10, 32'd7, 32'd0, 32'd7);
        idle_check("rem_7_0");
        run_div("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        idle_check("ovf");

        // Flush while CALC holds count=10.
        @(negedge clk);
        div_start = 1'b1;
        div_op    = 2'b00;
        op1       = 32'd1000;
        op2       = 32'd3;
        repeat (11) @(negedge clk);
        flush     = 1'b1;
        div_start = 1'b0;
        @(negedge clk);
        check("flush stall", {31'd0, stall}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result_kept", result, last_result);
        flush    = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        check("flush no_done", spurious, 0);
        run_div("div_100_7", 2'b00, 32'd100, 32'd7, 32'd14);
        idle_check("div_100_7");

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            rop = 2'(i % 4);
            run_div($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
        end
        idle_check("rand");

        run_div("divu_1000_10", 2'b01, 32'd1000, 32'd10, 32'd100);
        idle_check("divu_1000_10");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        div_start = 1'b1;
        div_op    = 2'b01;
        op1       = 32'd12345;
        op2       = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst done", {31'd0, done}, 32'd0);
        check("async_rst result", result, 32'd0);
        div_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst stall", {31'd0, stall}, 32'd0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        check("post_rst no_done", spurious, 0);

        run_div("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        idle_check("rem_m7_2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
